mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Next-generation MEM pipeline stage with registered MEM/WB outputs. Performs real
//  loads/stores over a req/ack data bus, handling byte-lane steering, sign/zero
//  extension, misalignment, bus timeout and pipeline stall. Sits between EX and WB;
//  stall_req_o feeds the pipeline controller.
// PARAMETERS
//  ADDR_W      32  data-bus address width (data width fixed at 32, 4 byte lanes)
//  REG_ADDR_W  5   destination register address width
//  BIG_ENDIAN  1   1: addr[1:0]=0 selects lane 3 (bits 31:24); 0: selects lane 0
//  TIMEOUT_CYC 255 max cycles waiting for dbus_ack_i; 0 disables timeout
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous reset, active-low
//  ex_valid_i    in   1           EX presents an instruction this cycle
//  wd_i          in   REG_ADDR_W  destination register
//  wreg_i        in   1           register write enable
//  wdata_i       in   32          ALU result (non-memory ops)
//  memop_i       in   4           0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW; 9-15 = NONE
//  mem_addr_i    in   ADDR_W      effective address
//  mem_wdata_i   in   32          store data (rt)
//  flush_i       in   1           discard instruction in stage
//  stall_req_o   out  1           hold EX/earlier stages
//  dbus_req_o    out  1           bus request, held until ack
//  dbus_we_o     out  1           1 store, 0 load
//  dbus_addr_o   out  ADDR_W      word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dbus_sel_o    out  4           byte enables
//  dbus_wdata_o  out  32          store data replicated to all lanes
//  dbus_ack_i    in   1           bus completion; rdata valid same cycle
//  dbus_rdata_i  in   32          load data word
//  wb_valid_o    out  1           one-cycle pulse: WB fields valid
//  wd_o          out  REG_ADDR_W  to WB
//  wreg_o        out  1           to WB
//  wdata_o       out  32          to WB
//  misalign_o    out  1           one-cycle pulse with wb_valid_o
//  bus_err_o     out  1           one-cycle pulse with wb_valid_o
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; counter 0; dbus_req_o drops at once.
//  - FSM IDLE/BUS. stall_req_o = (state==BUS), or IDLE with a valid aligned mem op accepted.
//  - IDLE, ex_valid_i && !flush_i:
//    * NONE: next edge wb_valid_o=1, wd/wreg/wdata = inputs (latency 1).
//    * Misaligned (H: addr[0]!=0; W: addr[1:0]!=0): no bus access; next edge wb_valid_o=1,
//      wreg_o=0, misalign_o=1.
//    * Aligned mem op: next edge -> BUS with dbus_req_o=1 and we/addr/sel/wdata registered.
//      sel: B one lane, H two lanes, W 4'b1111, mapped via BIG_ENDIAN.
//  - BUS: outputs held stable until ack. On dbus_ack_i the same edge returns to IDLE,
//    drops req and pulses wb_valid_o. Loads: lane extracted, LB/LH sign-extend,
//    LBU/LHU zero-extend, wreg_o=wreg_i. Stores: wreg_o=0. Min load latency 2 cycles.
//  - Timeout: counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYC:
//    return to IDLE, req=0, wb_valid_o=1, wreg_o=0, bus_err_o=1. Ack in that same cycle
//    wins (normal completion).
//  - flush_i in IDLE: nothing accepted, wb_valid_o=0. flush_i in BUS: transaction still
//    completes (no bus abort), result suppressed (wb_valid_o=0); flush remembered until ack.
//  - No input accepted while in BUS; EX must hold via stall_req_o.
//  - wb_valid_o, misalign_o and bus_err_o are single-cycle pulses; WB never back-pressures.
// TESTING
//  1 NONE, wd=5, wdata=0x1234 -> next cycle wb_valid=1, wd_o=5, wdata_o=0x1234, no req.
//  2 LB addr=0x101 (BIG_ENDIAN), rdata=0x11F233 44, ack after 3 cycles -> sel=4'b0100,
//    stall 4 cycles, wdata_o=0xFFFFFFF2; LBU same -> 0x000000F2.
//  3 SH addr=0x202, data=0xAAAABEEF -> sel=4'b0011, dbus_wdata=0xBEEFBEEF, we=1, wreg_o=0.
//  4 LW addr=0x103 -> no req, next cycle misalign_o=1, wreg_o=0.
//  5 TIMEOUT_CYC=4, LW never acked -> req high 4 cycles, then bus_err_o=1, stall released.
//  6 rst low mid-BUS -> req/stall/wb_valid to 0 immediately; flush_i in BUS -> ack, wb_valid=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage with registered MEM/WB outputs. Issues loads and stores
//   on a req/ack data bus. It handles byte-lane steering and sign/zero
//   extension of load data. Misaligned accesses are trapped without touching
//   the bus. A bus transaction that is never acknowledged is ended by a
//   timeout. A flush that arrives during a bus transaction lets the bus cycle
//   complete, but the result is dropped.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ex_valid_i        EX presents an instruction
//   wd_i, wreg_i      destination register / write enable
//   wdata_i           ALU result for non-memory ops
//   memop_i           0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW, others NONE
//   mem_addr_i        effective address
//   mem_wdata_i       store data
//   flush_i           discard the instruction in this stage
//   stall_req_o       hold EX and earlier stages
//   dbus_*_o          registered bus request, we, word address, byte enables, data
//   dbus_ack_i        bus completion, dbus_rdata_i valid in the same cycle
//   wb_valid_o        one-cycle pulse, WB fields valid
//   wd_o, wreg_o, wdata_o  result to WB
//   misalign_o        one-cycle pulse with wb_valid_o for a misaligned access
//   bus_err_o         one-cycle pulse with wb_valid_o on a bus timeout
module mem_access_stage #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_W-1:0]     dbus_addr_o,
    output logic [3:0]            dbus_sel_o,
    output logic [31:0]           dbus_wdata_o,
    input  logic                  dbus_ack_i,
    input  logic [31:0]           dbus_rdata_i,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  misalign_o,
    output logic                  bus_err_o
);

    typedef enum logic {S_IDLE, S_BUS} state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
        OP_LW   = 4'd5, OP_SB = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8
    } memop_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           bwdata_q, bwdata_d;
    memop_e                op_q, op_d;
    logic [1:0]            lo_q, lo_d;
    logic [REG_ADDR_W-1:0] pwd_q, pwd_d;
    logic                  pwreg_q, pwreg_d;
    logic                  flush_q, flush_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  wbv_q, wbv_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;

    // Request decode
    memop_e     op_in;
    logic       acc_b, acc_h, acc_w, acc_st, acc_mem, acc_mis, accept_bus;
    logic [1:0] lane_in;
    logic [3:0] sel_in;
    logic [31:0] wdata_rep;

    assign op_in = memop_e'(memop_i);

    always_comb begin
        acc_b  = 1'b0;
        acc_h  = 1'b0;
        acc_w  = 1'b0;
        acc_st = 1'b0;
        case (op_in)
            OP_LB, OP_LBU: acc_b = 1'b1;
            OP_LH, OP_LHU: acc_h = 1'b1;
            OP_LW:         acc_w = 1'b1;
            OP_SB: begin acc_b = 1'b1; acc_st = 1'b1; end
            OP_SH: begin acc_h = 1'b1; acc_st = 1'b1; end
            OP_SW: begin acc_w = 1'b1; acc_st = 1'b1; end
            default: ;
        endcase
        acc_mem = acc_b | acc_h | acc_w;
        acc_mis = (acc_h && mem_addr_i[0]) || (acc_w && (mem_addr_i[1:0] != 2'b00));

        // Physical lane of the addressed byte; big-endian puts offset 0 in lane 3
        lane_in = BIG_ENDIAN ? ~mem_addr_i[1:0] : mem_addr_i[1:0];

        sel_in    = 4'b1111;
        wdata_rep = mem_wdata_i;
        if (acc_b) begin
            sel_in    = 4'b0001 << lane_in;
            wdata_rep = {4{mem_wdata_i[7:0]}};
        end else if (acc_h) begin
            sel_in    = lane_in[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{mem_wdata_i[15:0]}};
        end
        accept_bus = acc_mem && !acc_mis;
    end

    // Load data extraction from the returned word
    logic [1:0]  byte_idx;
    logic        half_idx;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    always_comb begin
        byte_idx = BIG_ENDIAN ? ~lo_q : lo_q;
        half_idx = BIG_ENDIAN ? ~lo_q[1] : lo_q[1];
        ld_byte  = dbus_rdata_i[{byte_idx, 3'b000} +: 8];
        ld_half  = dbus_rdata_i[{half_idx, 4'b0000} +: 16];
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'd0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = dbus_rdata_i;
        endcase
    end

    // Ack in the timeout cycle takes priority, so this is only used without ack
    logic to_hit;
    assign to_hit = (TIMEOUT_CYC != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT_CYC));

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        bwdata_d = bwdata_q;
        op_d     = op_q;
        lo_d     = lo_q;
        pwd_d    = pwd_q;
        pwreg_d  = pwreg_q;
        flush_d  = flush_q;
        cnt_d    = cnt_q;
        wbv_d    = 1'b0;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid_i && !flush_i) begin
                    if (!acc_mem) begin
                        wbv_d   = 1'b1;
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        wdata_d = wdata_i;
                    end else if (acc_mis) begin
                        wbv_d   = 1'b1;
                        wd_d    = wd_i;
                        wreg_d  = 1'b0;
                        wdata_d = '0;
                        mis_d   = 1'b1;
                    end else begin
                        state_d  = S_BUS;
                        req_d    = 1'b1;
                        we_d     = acc_st;
                        addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        sel_d    = sel_in;
                        bwdata_d = wdata_rep;
                        op_d     = op_in;
                        lo_d     = mem_addr_i[1:0];
                        pwd_d    = wd_i;
                        pwreg_d  = wreg_i && !acc_st;
                        flush_d  = 1'b0;
                        cnt_d    = '0;
                    end
                end
            end
            S_BUS: begin
                if (dbus_ack_i || to_hit) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    flush_d = 1'b0;
                    cnt_d   = '0;
                    // A flush seen at any point in the transaction suppresses the result
                    if (!(flush_q || flush_i)) begin
                        wbv_d = 1'b1;
                        wd_d  = pwd_q;
                        if (dbus_ack_i) begin
                            wreg_d  = pwreg_q;
                            wdata_d = we_q ? '0 : ld_val;
                        end else begin
                            wreg_d  = 1'b0;
                            wdata_d = '0;
                            err_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d   = cnt_q + 32'd1;
                    flush_d = flush_q || flush_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            bwdata_q <= '0;
            op_q     <= OP_NONE;
            lo_q     <= '0;
            pwd_q    <= '0;
            pwreg_q  <= 1'b0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
            wbv_q    <= 1'b0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            bwdata_q <= bwdata_d;
            op_q     <= op_d;
            lo_q     <= lo_d;
            pwd_q    <= pwd_d;
            pwreg_q  <= pwreg_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
            wbv_q    <= wbv_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    assign stall_req_o  = (state_q == S_BUS) ||
                          (ex_valid_i && !flush_i && accept_bus);
    assign dbus_req_o   = req_q;
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_sel_o   = sel_q;
    assign dbus_wdata_o = bwdata_q;
    assign wb_valid_o   = wbv_q;
    assign wd_o         = wd_q;
    assign wreg_o       = wreg_q;
    assign wdata_o      = wdata_q;
    assign misalign_o   = mis_q;
    assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, wreg_i, flush_i, dbus_ack_i;
    logic [4:0]  wd_i;
    logic [31:0] wdata_i, mem_addr_i, mem_wdata_i, dbus_rdata_i;
    logic [3:0]  memop_i;
    logic        stall_req_o, dbus_req_o, dbus_we_o, wb_valid_o, wreg_o, misalign_o, bus_err_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, wdata_o;
    logic [3:0]  dbus_sel_o;
    logic [4:0]  wd_o;

    mem_access_stage #(
        .ADDR_W(32), .REG_ADDR_W(5), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .memop_i(memop_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
        .dbus_rdata_i(dbus_rdata_i), .wb_valid_o(wb_valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
        bit          chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        bit          flushed;
        bit          rabort;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=no-event at %0t", name, $time);
    endtask

    // Byte at memory offset k of a big-endian word
    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
        logic [31:0] t;
        t = w >> (8 * (3 - k));
        return t[7:0];
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (!wb_valid_o && (misalign_o || bus_err_o))
                fail_now("pulse_without_wb_valid");
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_wb_valid");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_wreg", {31'd0, wreg_o}, {31'd0, e.wreg});
                    chk("wb_misalign", {31'd0, misalign_o}, {31'd0, e.mis});
                    chk("wb_bus_err", {31'd0, bus_err_o}, {31'd0, e.err});
                    if (e.chk_data) begin
                        chk("wb_wd", {27'd0, wd_o}, {27'd0, e.wd});
                        chk("wb_wdata", wdata_o, e.wdata);
                    end
                end
            end
        end
    end

    // Bus responder
    plan_t cur;
    bit    busy  = 0;
    bit    acked = 0;
    int    wcnt  = 0;

    initial begin
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = '0;
        forever begin
            @(negedge clk);
            dbus_ack_i   = 1'b0;
            dbus_rdata_i = $urandom;
            if (acked) begin
                acked = 0;
                chk("ack_req_drop", {31'd0, dbus_req_o}, 32'd0);
                chk("ack_wb_valid", {31'd0, wb_valid_o}, {31'd0, !cur.flushed});
            end else if (busy && !dbus_req_o) begin
                busy = 0;
                if (!cur.rabort) begin
                    chk("timeout_cycles", wcnt, TO);
                    chk("timeout_wb_valid", {31'd0, wb_valid_o}, {31'd0, !cur.flushed});
                end
            end else if (dbus_req_o) begin
                if (!busy) begin
                    if (plan_q.size() == 0) begin
                        fail_now("unplanned_bus_req");
                    end else begin
                        cur  = plan_q.pop_front();
                        busy = 1;
                        wcnt = 0;
                    end
                end
                if (busy) begin
                    chk("bus_addr", dbus_addr_o, cur.addr);
                    chk("bus_we", {31'd0, dbus_we_o}, {31'd0, cur.we});
                    chk("bus_sel", {28'd0, dbus_sel_o}, {28'd0, cur.sel});
                    chk("bus_wdata", dbus_wdata_o, cur.wdata);
                    if (wcnt == cur.lat) begin
                        dbus_ack_i   = 1'b1;
                        dbus_rdata_i = cur.rdata;
                        acked        = 1;
                        busy         = 0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // Issue one instruction; caller is at a negedge with the stage idle
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata, input logic [31:0] st,
                         input int lat, input logic [31:0] rdata, input bit fl, input bit rabort);
        bit   ld, stv, bus, mis;
        int   sz, k, n;
        exp_t  e;
        plan_t p;
        logic [7:0] b0, b1;

        k   = int'(addr[1:0]);
        ld  = (op >= 4'd1 && op <= 4'd5);
        stv = (op >= 4'd6 && op <= 4'd8);
        sz  = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 1 :
              (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 :
              (op == 4'd5 || op == 4'd8) ? 4 : 0;
        mis = (sz == 2 && (k % 2) != 0) || (sz == 4 && k != 0);
        bus = (ld || stv) && !mis;

        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.mis = 0; e.err = 0; e.chk_data = 1;
        if (mis) begin
            e.wreg = 0; e.mis = 1; e.chk_data = 0;
        end else if (bus) begin
            p.addr = {addr[31:2], 2'b00};
            p.we   = stv;
            p.sel  = '0;
            for (int i = 0; i < sz; i++) p.sel[3 - (k + i)] = 1'b1;
            p.wdata   = (sz == 1) ? {4{st[7:0]}} : (sz == 2) ? {2{st[15:0]}} : st;
            p.lat     = lat;
            p.rdata   = rdata;
            p.flushed = fl;
            p.rabort  = rabort;
            plan_q.push_back(p);
            if (lat >= TO) begin
                e.wreg = 0; e.err = 1; e.chk_data = 0;
            end else if (stv) begin
                e.wreg = 0; e.chk_data = 0;
            end else begin
                b0 = byte_at(rdata, k);
                b1 = byte_at(rdata, (k + 1) % 4);
                case (op)
                    4'd1:    e.wdata = {{24{b0[7]}}, b0};
                    4'd2:    e.wdata = {24'd0, b0};
                    4'd3:    e.wdata = {{16{b0[7]}}, b0, b1};
                    4'd4:    e.wdata = {16'd0, b0, b1};
                    default: e.wdata = rdata;
                endcase
            end
        end
        if (!(bus && (fl || rabort))) exp_q.push_back(e);

        ex_valid_i = 1'b1; memop_i = op; mem_addr_i = addr; wd_i = wd;
        wreg_i = wreg; wdata_i = wdata; mem_wdata_i = st; flush_i = 1'b0;
        #1;
        chk("stall_on_accept", {31'd0, stall_req_o}, {31'd0, bus});
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs while the stage is busy; none of it may leak into results
        ex_valid_i = 1'b0; memop_i = 4'($urandom); mem_addr_i = $urandom;
        wd_i = 5'($urandom); wdata_i = $urandom; mem_wdata_i = $urandom;
        if (!bus) chk("latency1_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        if (rabort) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
            chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
            chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            return;
        end
        if (bus && fl) begin
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
        end
        n = 0;
        while (stall_req_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (stall_req_o) fail_now("stall_never_released");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ex_valid_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0; memop_i = 0;
        mem_addr_i = 0; mem_wdata_i = 0; flush_i = 0;
        repeat (3) @(negedge clk);
        chk("reset_req", {31'd0, dbus_req_o}, 32'd0);
        chk("reset_stall", {31'd0, stall_req_o}, 32'd0);
        chk("reset_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("reset_misalign", {31'd0, misalign_o}, 32'd0);
        chk("reset_bus_err", {31'd0, bus_err_o}, 32'd0);
        chk("reset_wdata", wdata_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'd0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0, 32'h0, 0, 0);
        issue(4'd1, 32'h101, 5'd7, 1'b1, 32'h0, 32'h0, 2, 32'h11F23344, 0, 0);
        issue(4'd2, 32'h101, 5'd7, 1'b1, 32'h0, 32'h0, 2, 32'h11F23344, 0, 0);
        issue(4'd7, 32'h202, 5'd3, 1'b1, 32'h0, 32'hAAAABEEF, 1, 32'h0, 0, 0);
        issue(4'd5, 32'h103, 5'd4, 1'b1, 32'h0, 32'h0, 0, 32'h0, 0, 0);
        issue(4'd5, 32'h100, 5'd4, 1'b1, 32'h0, 32'h0, 100, 32'h0, 0, 0);
        issue(4'd5, 32'h100, 5'd4, 1'b1, 32'h0, 32'h0, TO - 1, 32'hCAFEF00D, 0, 0);
        issue(4'd3, 32'h102, 5'd9, 1'b1, 32'h0, 32'h0, 0, 32'h1234_8001, 0, 0);
        issue(4'd5, 32'h104, 5'd2, 1'b1, 32'h0, 32'h0, 1, 32'h55555555, 1, 0);

        // Flush in IDLE: nothing accepted
        ex_valid_i = 1'b1; flush_i = 1'b1; memop_i = 4'd5; mem_addr_i = 32'h200;
        #1;
        chk("flush_idle_stall", {31'd0, stall_req_o}, 32'd0);
        @(negedge clk);
        ex_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_req", {31'd0, dbus_req_o}, 32'd0);
        chk("flush_idle_wb", {31'd0, wb_valid_o}, 32'd0);

        // Reset in the middle of a bus transaction
        issue(4'd5, 32'h300, 5'd1, 1'b1, 32'h0, 32'h0, 100, 32'h0, 0, 1);
        @(negedge clk);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            issue(op, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom,
                  $urandom_range(0, 6), $urandom, ($urandom_range(0, 7) == 0), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("bus_plans_empty", plan_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
